// File: rtl/abh_if.sv
// abh_if: high-byte address stage signal bundle between sequencer/ALU side and abh
interface abh_if;
    logic       CI;
    logic       pcl_co;
    logic [7:0] DB;
    logic       branch;
    logic [3:0] op;
    logic       ld_ahh;
    logic       ld_pc;
    logic       stall;
    logic [7:0] ADH;
    logic [7:0] ABH;
    logic [7:0] PCH;
    logic [7:0] AHH;
    modport master (
        output CI, pcl_co, DB, branch, op, ld_ahh, ld_pc,
        input  stall, ADH, ABH, PCH, AHH
    );
    modport slave (
        input  CI, pcl_co, DB, branch, op, ld_ahh, ld_pc,
        output stall, ADH, ABH, PCH, AHH
    );
endinterface

// File: rtl/abh.sv
// abh: 65C02 address-bus high byte with PCH/AHH holding and page-cross fixup
module abh (
    input logic  clk,
    input logic  RST,
    abh_if.slave bus
);
    typedef enum logic {IDLE, FIX} state_t;
    state_t     state;
    logic [7:0] abh_q, pch_q, ahh_q, adh, ci8, off;
    logic       fix;
    assign ci8 = {7'b0, bus.CI};
    assign off = bus.branch ? {8{bus.DB[7]}} : 8'h00;
    assign fix = state == IDLE && bus.op == 4'b1101 && bus.CI;
    // High-address source select; a crossing first emits the uncorrected AHH, then ABH+1
    always_comb begin
        adh = 8'h00;
        case (bus.op[2:0])
            3'b000:  adh = 8'h00;
            3'b001:  adh = 8'h01;
            3'b010:  adh = 8'hFF;
            3'b011:  adh = pch_q + ci8;
            3'b100:  adh = bus.DB + ci8;
            3'b101:  adh = fix ? ahh_q : ahh_q + ci8;
            3'b110:  adh = abh_q + ci8;
            default: adh = abh_q + off + ci8;
        endcase
        if (state == FIX) adh = abh_q + 8'h01;
    end
    // Address, PC high, operand high registers and the fixup state
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            abh_q <= 8'h00;
            pch_q <= 8'h00;
            ahh_q <= 8'h00;
        end else begin
            state <= fix ? FIX : IDLE;
            abh_q <= adh;
            if (bus.ld_pc) pch_q <= abh_q + {7'b0, bus.pcl_co};
            if (bus.ld_ahh) ahh_q <= bus.DB;
        end
    end
    assign bus.stall = fix;
    assign bus.ADH   = adh;
    assign bus.ABH   = abh_q;
    assign bus.PCH   = pch_q;
    assign bus.AHH   = ahh_q;
endmodule

// File: tb/tb_abh.sv
// tb_abh: directed self-checking bench for abh
module tb_abh;
    logic clk = 1'b0;
    logic RST;
    int   checks = 0;
    int   failures = 0;
    abh_if bus ();
    abh dut (.clk(clk), .RST(RST), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] op, input logic ci, input logic [7:0] db);
        bus.op = op;
        bus.CI = ci;
        bus.DB = db;
        #1;
    endtask
    initial begin
        RST = 1'b1;
        bus.CI = 0; bus.pcl_co = 0; bus.DB = 0; bus.branch = 0;
        bus.op = 0; bus.ld_ahh = 0; bus.ld_pc = 0;
        tick();
        RST = 1'b0;
        // load nonzero into all registers
        bus.ld_ahh = 1; bus.ld_pc = 1; bus.pcl_co = 1;
        drive(4'b0010, 0, 8'hAA);
        tick();
        bus.ld_ahh = 0; bus.ld_pc = 0; bus.pcl_co = 0;
        check("pre_abh", bus.ABH, 8'hFF);
        check("pre_pch", bus.PCH, 8'h01);
        check("pre_ahh", bus.AHH, 8'hAA);
        // enter FIX, then reset inside FIX
        drive(4'b1101, 1, 8'h00);
        check("x_adh", bus.ADH, 8'hAA);
        check("x_stall", {7'b0, bus.stall}, 8'h01);
        tick();
        drive(4'b0001, 0, 8'h00);
        check("x_fix_adh", bus.ADH, 8'hAB);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("rst_abh", bus.ABH, 8'h00);
        check("rst_pch", bus.PCH, 8'h00);
        check("rst_ahh", bus.AHH, 8'h00);
        check("rst_stall", {7'b0, bus.stall}, 8'h00);
        check("rst_adh", bus.ADH, 8'h01);
        // page-cross fixup
        bus.ld_ahh = 1;
        drive(4'b0000, 0, 8'h12);
        tick();
        bus.ld_ahh = 0;
        drive(4'b1101, 1, 8'h00);
        check("fx1_adh", bus.ADH, 8'h12);
        check("fx1_stall", {7'b0, bus.stall}, 8'h01);
        tick();
        drive(4'b1101, 1, 8'h55);
        check("fx2_adh", bus.ADH, 8'h13);
        check("fx2_stall", {7'b0, bus.stall}, 8'h00);
        tick();
        drive(4'b0000, 0, 8'h00);
        check("fx3_abh", bus.ABH, 8'h13);
        check("fx3_adh", bus.ADH, 8'h00);
        check("fx3_stall", {7'b0, bus.stall}, 8'h00);
        drive(4'b1101, 0, 8'h00);
        check("nc_adh", bus.ADH, 8'h12);
        check("nc_stall", {7'b0, bus.stall}, 8'h00);
        // wrap without fixup, and ld_ahh concurrent with AHH source
        bus.ld_ahh = 1;
        drive(4'b0000, 0, 8'hFF);
        tick();
        drive(4'b0101, 1, 8'h34);
        check("wrap_adh", bus.ADH, 8'h00);
        check("wrap_stall", {7'b0, bus.stall}, 8'h00);
        drive(4'b0101, 0, 8'h34);
        check("ldahh_old", bus.ADH, 8'hFF);
        tick();
        bus.ld_ahh = 0;
        drive(4'b0101, 0, 8'h00);
        check("ldahh_new", bus.ADH, 8'h34);
        // branch arithmetic around ABH=20
        drive(4'b0100, 0, 8'h20);
        check("db_adh", bus.ADH, 8'h20);
        tick();
        bus.branch = 1;
        drive(4'b0111, 0, 8'hF0);
        check("br_neg", bus.ADH, 8'h1F);
        drive(4'b0111, 1, 8'hF0);
        check("br_neg_c", bus.ADH, 8'h20);
        drive(4'b0111, 1, 8'h10);
        check("br_pos_c", bus.ADH, 8'h21);
        bus.branch = 0;
        drive(4'b0111, 1, 8'hF0);
        check("br_not", bus.ADH, 8'h21);
        drive(4'b0110, 1, 8'h00);
        check("stay_c", bus.ADH, 8'h21);
        // PC high load with carry wrap
        drive(4'b0010, 0, 8'h00);
        tick();
        bus.ld_pc = 1; bus.pcl_co = 1;
        tick();
        bus.ld_pc = 0; bus.pcl_co = 0;
        check("pc_wrap", bus.PCH, 8'h00);
        drive(4'b0011, 0, 8'h00);
        check("pc_adh", bus.ADH, 8'h00);
        bus.ld_pc = 1;
        drive(4'b0010, 0, 8'h00);
        tick();
        bus.ld_pc = 0;
        check("pc_noco", bus.PCH, 8'hFF);
        drive(4'b0011, 1, 8'h00);
        check("pc_adh_c", bus.ADH, 8'h00);
        // ld_pc during FIX uses pre-edge ABH
        bus.ld_ahh = 1;
        drive(4'b0000, 0, 8'h40);
        tick();
        bus.ld_ahh = 0;
        drive(4'b1101, 1, 8'h00);
        tick();
        bus.ld_pc = 1; bus.pcl_co = 1;
        drive(4'b0000, 0, 8'h00);
        check("fixpc_adh", bus.ADH, 8'h41);
        tick();
        bus.ld_pc = 0; bus.pcl_co = 0;
        check("fixpc_pch", bus.PCH, 8'h41);
        check("fixpc_abh", bus.ABH, 8'h41);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
